subtractor_nbit_seq: RTL



---
 rtl/subtractor_nbit_seq_pkg.sv | 15 +
 rtl/subtractor_digit.sv | 15 +
 rtl/subtractor_nbit_seq.sv | 114 +++++++++++
 3 files changed

// File: rtl/subtractor_nbit_seq_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter width for NDIG digits; never narrower than one bit.
  function automatic int cnt_width(input int ndig);
    return (ndig <= 1) ? 1 : $clog2(ndig);
  endfunction

endpackage

// File: rtl/subtractor_digit.sv
// One W-bit digit of subtraction: {bo, diff} = x - y - bi.
module subtractor_digit #(
  parameter int W = 2
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         bi,
  output logic [W-1:0] diff,
  output logic         bo
);

  // One extra bit catches the wrap-around, which is exactly the borrow.
  assign {bo, diff} = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};

endmodule

// File: rtl/subtractor_nbit_seq.sv
// Digit-serial N-bit subtractor: W bits per clock, LSB digit first, borrow
// rippled through a register; valid/ready on both operand and result sides.
module subtractor_nbit_seq
  import sub_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] d,
  output logic         bout
);

  localparam int NDIG = N / W;
  localparam int CW   = cnt_width(NDIG);

  if (W < 1 || W > N || (N % W) != 0) begin : g_bad_params
    $error("subtractor_nbit_seq: W must be in 1..N and divide N");
  end

  state_e         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic           borrow_q, borrow_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   d_q, d_d;
  logic           bout_q, bout_d;

  logic [W-1:0]   dig_diff;
  logic           dig_bo;

  subtractor_digit #(.W(W)) u_digit (
    .x    (a_q[W-1:0]),
    .y    (b_q[W-1:0]),
    .bi   (borrow_q),
    .diff (dig_diff),
    .bo   (dig_bo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      d_q      <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      d_q      <= d_d;
      bout_q   <= bout_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    d_d      = d_q;
    bout_d   = bout_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          cnt_d    = '0;
          d_d      = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        a_d      = a_q >> W;
        b_d      = b_q >> W;
        borrow_d = dig_bo;
        cnt_d    = cnt_q + CW'(1);
        // Digits land in place so d never shows a shifted partial result.
        for (int i = 0; i < NDIG; i++) begin
          if (cnt_q == CW'(i)) d_d[i*W +: W] = dig_diff;
        end
        if (cnt_q == CW'(NDIG - 1)) begin
          bout_d  = dig_bo;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign d         = d_q;
  assign bout      = bout_q;

endmodule
